// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding common to uart_rx and uart_tx,
// bit timing constants and the default frame shape.
package uart_pkg;

    // State encoding shared by the receiver and the transmitter.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        DATA  = ST_DATA,
        STOP  = ST_STOP
    } uart_state_e;

    // Oversampling ratio of the shared baud generator.
    localparam int TICKS_PER_BIT = 16;

    // Default frame shape: 8 data bits, one 16-tick stop bit.
    localparam int DEF_NB_DATA = 8;
    localparam int DEF_NB_STOP = 16;

    // Length of one frame in baud ticks (start + data + stop).
    function automatic int frame_ticks(input int nb_data, input int nb_stop);
        return TICKS_PER_BIT * (1 + nb_data) + nb_stop;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART serializer. Sends one NB_DATA-bit word as start bit, data LSB first
// and a stop period of NB_STOP ticks, timed by the 16x oversampling strobe.
//
// Request handshake: i_tx_start is sampled only while the FSM is idle; a
// sample of 1 there accepts i_data (no ready signal is returned, o_busy rises
// on the next clk). Requests while busy are dropped, never queued. o_txdone
// pulses for one clk when the stop period ends, and a request in that same
// clk is accepted, giving back-to-back frames with no idle gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int NB_DATA     = DEF_NB_DATA,
    parameter int NB_STOP     = DEF_NB_STOP,
    parameter int NB_TICK_CNT = 5
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_tick,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_tx,
    output logic               o_busy,
    output logic               o_txdone
);

    localparam int NB_BIT_CNT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [NB_TICK_CNT-1:0] TICK_LAST = NB_TICK_CNT'(TICKS_PER_BIT - 1);
    localparam logic [NB_TICK_CNT-1:0] STOP_LAST = NB_TICK_CNT'(NB_STOP - 1);
    localparam logic [NB_BIT_CNT-1:0]  BIT_LAST  = NB_BIT_CNT'(NB_DATA - 1);

    uart_state_e            state;
    uart_state_e            state_n;
    logic [NB_TICK_CNT-1:0] tick_cnt;
    logic [NB_TICK_CNT-1:0] tick_cnt_n;
    logic [NB_BIT_CNT-1:0]  bit_cnt;
    logic [NB_BIT_CNT-1:0]  bit_cnt_n;
    logic [NB_DATA-1:0]     shreg;
    logic [NB_DATA-1:0]     shreg_n;
    logic                   tx_n;
    logic                   busy_n;
    logic                   txdone_n;

    // State register: FSM, counters, shift register and the registered outputs.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            o_tx     <= 1'b1;
            o_busy   <= 1'b0;
            o_txdone <= 1'b0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_cnt_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            o_tx     <= tx_n;
            o_busy   <= busy_n;
            o_txdone <= txdone_n;
        end
    end

    // Next-state logic: counters only move on ticks; acceptance ignores ticks.
    always_comb begin
        state_n    = state;
        tick_cnt_n = tick_cnt;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        case (state)
            IDLE: begin
                if (i_tx_start) begin
                    state_n    = START;
                    tick_cnt_n = '0;
                    bit_cnt_n  = '0;
                    shreg_n    = i_data;
                end
            end
            START: begin
                if (i_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt_n = '0;
                        bit_cnt_n  = '0;
                        state_n    = DATA;
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt_n = '0;
                        shreg_n    = {1'b0, shreg[NB_DATA-1:1]};
                        if (bit_cnt == BIT_LAST) begin
                            state_n = STOP;
                        end else begin
                            bit_cnt_n = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (tick_cnt == STOP_LAST) begin
                        tick_cnt_n = '0;
                        state_n    = IDLE;
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Output logic: computed from the upcoming state so the registers line up
    // with the state they describe.
    always_comb begin
        tx_n     = 1'b1;
        busy_n   = (state_n != IDLE);
        txdone_n = (state == STOP) && (state_n == IDLE);
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[0];
            default: tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (1 and 2 stop bits) checked every cycle
// against a tick-count model of the frame, plus a mid-bit sampler acting as
// the receiver and literal expectations for the received words and latencies.
module tb_uart_tx;

    localparam int TICK_DIV  = 4;
    localparam int MAX_PRINT = 40;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       start_v [2];
    logic [7:0] data_v  [2];
    logic       tx_w    [2];
    logic       busy_w  [2];
    logic       done_w  [2];

    int checks   = 0;
    int failures = 0;

    // Model state: frame in flight, ticks since acceptance, latched word.
    logic       m_active [2] = '{1'b0, 1'b0};
    int         m_n      [2] = '{0, 0};
    logic [7:0] m_word   [2] = '{8'h00, 8'h00};
    logic       m_done   [2] = '{1'b0, 1'b0};

    logic [7:0] rx_word  [2] = '{8'h00, 8'h00};
    int         done_cnt [2] = '{0, 0};
    int         acc_tick [2] = '{0, 0};
    int         tick_total = 0;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    uart_tx #(.NB_DATA(8), .NB_STOP(16), .NB_TICK_CNT(5)) dut (
        .clk(clk), .i_rst(rst), .i_tick(tick), .i_tx_start(start_v[0]),
        .i_data(data_v[0]), .o_tx(tx_w[0]), .o_busy(busy_w[0]), .o_txdone(done_w[0])
    );

    uart_tx #(.NB_DATA(8), .NB_STOP(32), .NB_TICK_CNT(5)) dut32 (
        .clk(clk), .i_rst(rst), .i_tick(tick), .i_tx_start(start_v[1]),
        .i_data(data_v[1]), .o_tx(tx_w[1]), .o_busy(busy_w[1]), .o_txdone(done_w[1])
    );

    // ---------------- clock / reset / tick ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        int div;
        div  = 0;
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tick = (div == TICK_DIV - 1);
            div  = (div + 1) % TICK_DIV;
        end
    end

    always @(posedge clk) begin
        if (tick) tick_total <= tick_total + 1;
    end

    // ---------------- model ----------------
    function automatic int total_ticks(input int u);
        return 16 * 9 + ((u == 1) ? 32 : 16);
    endfunction

    // Line level n ticks into a frame: 16 ticks low, 8 data windows, then high.
    function automatic logic line_at(input int n, input logic [7:0] w);
        if (n < 16) return 1'b0;
        if (n < 16 * 9) return w[(n - 16) / 16];
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int u = 0; u < 2; u++) begin
                m_active[u] <= 1'b0;
                m_n[u]      <= 0;
                m_done[u]   <= 1'b0;
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                m_done[u] <= 1'b0;
                if (m_active[u]) begin
                    if (tick) begin
                        m_n[u] <= m_n[u] + 1;
                        if (m_n[u] + 1 == total_ticks(u)) begin
                            m_active[u] <= 1'b0;
                            m_done[u]   <= 1'b1;
                        end
                    end
                end else if (start_v[u]) begin
                    m_active[u] <= 1'b1;
                    m_n[u]      <= 0;
                    m_word[u]   <= data_v[u];
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            if (failures <= MAX_PRINT)
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle compare against the model, plus the mid-bit receiver.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            logic e_tx;
            e_tx = m_active[u] ? line_at(m_n[u], m_word[u]) : 1'b1;
            check($sformatf("tx[%0d]", u), {31'd0, tx_w[u]}, {31'd0, e_tx});
            check($sformatf("busy[%0d]", u), {31'd0, busy_w[u]}, {31'd0, m_active[u]});
            check($sformatf("txdone[%0d]", u), {31'd0, done_w[u]}, {31'd0, m_done[u]});
            if (m_active[u] && m_n[u] >= 24 && m_n[u] < 144 && (m_n[u] % 16) == 8)
                rx_word[u][(m_n[u] - 16) / 16] = tx_w[u];
            if (m_done[u]) begin
                logic [7:0] e_w;
                done_cnt[u] = done_cnt[u] + 1;
                if (u == 0) e_w = (exp_q0.size() > 0) ? exp_q0.pop_front() : 8'hxx;
                else        e_w = (exp_q1.size() > 0) ? exp_q1.pop_front() : 8'hxx;
                check($sformatf("rx_word[%0d]", u), {24'd0, rx_word[u]}, {24'd0, e_w});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic accept(input int u, input logic [7:0] w);
        @(negedge clk);
        start_v[u] = 1'b1;
        data_v[u]  = w;
        @(negedge clk);
        start_v[u]  = 1'b0;
        acc_tick[u] = tick_total;
        check("accept_busy", {31'd0, busy_w[u]}, 32'd1);
    endtask

    task automatic wait_frame_ticks(input int u, input int n);
        int guard;
        guard = 0;
        while (tick_total - acc_tick[u] < n && guard < 20 * n + 100) begin
            @(negedge clk);
            guard++;
        end
        if (tick_total - acc_tick[u] < n) check("wait_ticks_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int u, input int exp_lat);
        int guard;
        guard = 0;
        while (!done_w[u] && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("done_seen", {31'd0, done_w[u]}, 32'd1);
        check("done_latency", tick_total - acc_tick[u], exp_lat);
    endtask

    // ---------------- sequence ----------------
    initial begin
        int t0;
        rst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            start_v[u] = 1'b0;
            data_v[u]  = 8'h00;
        end
        #1 rst = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_tx", {31'd0, tx_w[0]}, 32'd1);
        check("rst_busy", {31'd0, busy_w[0]}, 32'd0);
        check("rst_done", {31'd0, done_w[0]}, 32'd0);
        rst = 1'b0;

        // 1. idle for 200 ticks
        t0 = tick_total;
        while (tick_total - t0 < 200) @(negedge clk);
        check("idle_tx", {31'd0, tx_w[0]}, 32'd1);
        check("idle_busy", {31'd0, busy_w[0]}, 32'd0);

        // 2. single frame 8'hA5
        exp_q0.push_back(8'hA5);
        accept(0, 8'hA5);
        wait_done(0, 160);

        // 3. 8'h5A with a stray request carrying 8'hFF mid-frame
        exp_q0.push_back(8'h5A);
        accept(0, 8'h5A);
        wait_frame_ticks(0, 40);
        start_v[0] = 1'b1;
        data_v[0]  = 8'hFF;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, 160);
        repeat (200) @(negedge clk);
        check("no_second_frame", {31'd0, busy_w[0]}, 32'd0);

        // 4. request held high: 8'h00 then 8'hFF back to back
        exp_q0.push_back(8'h00);
        exp_q0.push_back(8'hFF);
        @(negedge clk);
        start_v[0] = 1'b1;
        data_v[0]  = 8'h00;
        @(negedge clk);
        acc_tick[0] = tick_total;
        data_v[0]   = 8'hFF;
        wait_done(0, 160);
        @(negedge clk);
        acc_tick[0] = tick_total;
        start_v[0]  = 1'b0;
        check("b2b_busy", {31'd0, busy_w[0]}, 32'd1);
        check("b2b_start_bit", {31'd0, tx_w[0]}, 32'd0);
        wait_done(0, 160);

        // 5. reset 70 ticks into an 8'h3C frame, then 8'hC3
        accept(0, 8'h3C);
        wait_frame_ticks(0, 70);
        #1 rst = 1'b1;
        #1;
        check("abort_tx", {31'd0, tx_w[0]}, 32'd1);
        check("abort_busy", {31'd0, busy_w[0]}, 32'd0);
        check("abort_done", {31'd0, done_w[0]}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q0.push_back(8'hC3);
        accept(0, 8'hC3);
        wait_done(0, 160);

        // 6. two stop bits, 8'h81
        exp_q1.push_back(8'h81);
        accept(1, 8'h81);
        wait_done(1, 176);
        repeat (20) @(negedge clk);

        check("frames_dut", done_cnt[0], 32'd5);
        check("frames_dut32", done_cnt[1], 32'd1);
        check("exp_q0_empty", exp_q0.size(), 32'd0);
        check("exp_q1_empty", exp_q1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
